// File: rtl/lsu_mem_access.sv
// Load/store unit: one memory op at a time over a valid/ready data bus, with load alignment/extension.
// Optional response watchdog enabled by defining LSU_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module lsu_mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_we,
  output logic [3:0]  mem_req_wstrb,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        st_done,
  output logic        err_valid,
  output logic [31:0] err_addr
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_ERR} state_t;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic        is_store_q;
  logic        accept;
  logic [3:0]  lane_wstrb;
  logic [31:0] lane_wdata;
  logic [31:0] load_lane;
  logic [31:0] load_data;

  // Legal funct3 for the op kind, plus natural alignment of the byte address.
  function automatic logic op_ok(input logic is_store, input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000:  return 1'b1;
      3'b001:  return !a[0];
      3'b010:  return a == 2'b00;
      3'b100:  return !is_store;
      3'b101:  return !is_store && !a[0];
      default: return 1'b0;
    endcase
  endfunction

  assign accept = ex_valid && (state_q == S_IDLE);

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             timeout_hit;

  assign timeout_hit = (tmo_cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

  // REQ is only entered from IDLE, so clearing while idle clears on entry to REQ.
  always_ff @(posedge clk) begin
    if (rst)                                        tmo_cnt_q <= '0;
    else if (state_q == S_IDLE)                     tmo_cnt_q <= '0;
    else if (state_q == S_REQ || state_q == S_WAIT) tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end
`endif

  always_comb begin
    // NOTE: default assigned first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = op_ok(ex_is_store, ex_funct3, ex_addr[1:0]) ? S_REQ : S_ERR;
      S_REQ: begin
        if (mem_req_ready) state_d = S_WAIT;
`ifdef LSU_TIMEOUT_EN
        else if (timeout_hit) state_d = S_ERR;
`endif
      end
      S_WAIT: begin
        if (mem_resp_valid) state_d = S_RESP;
`ifdef LSU_TIMEOUT_EN
        else if (timeout_hit) state_d = S_ERR;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      funct3_q   <= '0;
      rd_q       <= '0;
      is_store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q     <= ex_addr;
        wdata_q    <= ex_wdata;
        funct3_q   <= ex_funct3;
        rd_q       <= ex_rd;
        is_store_q <= ex_is_store;
      end
      if (state_q == S_WAIT && mem_resp_valid) rdata_q <= mem_resp_rdata;
    end
  end

  // Store lane placement: replicate the narrow datum, strobe selects the target bytes.
  always_comb begin
    lane_wstrb = 4'hF;
    lane_wdata = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        lane_wstrb = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane_wstrb = 4'b0011 << addr_q[1:0];
        lane_wdata = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  assign load_lane = rdata_q >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  load_data = {{24{load_lane[7]}}, load_lane[7:0]};
      3'b001:  load_data = {{16{load_lane[15]}}, load_lane[15:0]};
      3'b100:  load_data = {24'h0, load_lane[7:0]};
      3'b101:  load_data = {16'h0, load_lane[15:0]};
      default: load_data = rdata_q;
    endcase
  end

  assign ex_ready      = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_addr  = {addr_q[31:2], 2'b00};
  assign mem_req_we    = (state_q == S_REQ) && is_store_q;
  assign mem_req_wstrb = mem_req_we ? lane_wstrb : 4'h0;
  assign mem_req_wdata = lane_wdata;
  assign wb_valid      = (state_q == S_RESP) && !is_store_q;
  assign wb_rd         = rd_q;
  assign wb_data       = load_data;
  assign st_done       = (state_q == S_RESP) && is_store_q;
  assign err_valid     = (state_q == S_ERR);
  assign err_addr      = addr_q;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Self-checking bench for lsu_mem_access: table of single ops plus hand-written multi-cycle sequences.
module tb_lsu_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        wb_valid, st_done, err_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, err_addr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lsu_mem_access #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
    .mem_req_wstrb(mem_req_wstrb), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .st_done(st_done), .err_valid(err_valid), .err_addr(err_addr)
  );

  typedef struct {
    logic        is_store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        exp_err;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wb;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdata,
                              input logic err, input logic [3:0] wstrb, input logic [31:0] ewd,
                              input logic [31:0] wb);
    vec_t v;
    v.is_store = st; v.f3 = f3; v.addr = addr; v.wdata = wd; v.rd = rd; v.rdata = rdata;
    v.exp_err = err; v.exp_wstrb = wstrb; v.exp_wdata = ewd; v.exp_wb = wb;
    return v;
  endfunction

  task automatic offer(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd);
    ex_valid = 1'b1; ex_is_store = st; ex_funct3 = f3; ex_addr = addr; ex_wdata = wd; ex_rd = rd;
  endtask

  // Applies one op with immediate ready and response; DUT expected idle on entry.
  task automatic run_op(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    offer(v.is_store, v.f3, v.addr, v.wdata, v.rd);
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0;
    check({t, " ex_ready idle"}, 32'(ex_ready), 32'd1);
    step();
    ex_valid = 1'b0;
    if (v.exp_err) begin
      check({t, " err_valid"}, 32'(err_valid), 32'd1);
      check({t, " err_addr"}, err_addr, v.addr);
      check({t, " no req on err"}, 32'(mem_req_valid), 32'd0);
      step();
      check({t, " ex_ready after err"}, 32'(ex_ready), 32'd1);
      check({t, " err one cycle"}, 32'(err_valid), 32'd0);
      return;
    end
    check({t, " req_valid"}, 32'(mem_req_valid), 32'd1);
    check({t, " req_addr"}, mem_req_addr, v.addr & 32'hFFFF_FFFC);
    check({t, " req_we"}, 32'(mem_req_we), 32'(v.is_store));
    check({t, " req_wstrb"}, 32'(mem_req_wstrb), 32'(v.exp_wstrb));
    if (v.is_store) check({t, " req_wdata"}, mem_req_wdata, v.exp_wdata);
    step();
    check({t, " req dropped in wait"}, 32'(mem_req_valid), 32'd0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = v.rdata;
    step();
    mem_resp_valid = 1'b0;
    check({t, " wb_valid"}, 32'(wb_valid), 32'(!v.is_store));
    check({t, " st_done"}, 32'(st_done), 32'(v.is_store));
    if (!v.is_store) begin
      check({t, " wb_rd"}, 32'(wb_rd), 32'(v.rd));
      check({t, " wb_data"}, wb_data, v.exp_wb);
    end
    step();
    check({t, " back idle"}, 32'(ex_ready), 32'd1);
    check({t, " wb pulse one cycle"}, 32'(wb_valid | st_done), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; ex_is_store = 1'b0; ex_funct3 = 3'd0; ex_addr = '0; ex_wdata = '0; ex_rd = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;

    //         st f3  addr          wdata         rd     rdata         err wstrb    exp_wdata     exp_wb
    vecs.push_back(mk(0, 3'd2, 32'h8000_0010, 32'h0,        5'd5,  32'hDEAD_BEEF, 0, 4'b0000, 32'h0,        32'hDEAD_BEEF));
    vecs.push_back(mk(0, 3'd0, 32'h8000_0003, 32'h0,        5'd7,  32'h80FF_7F01, 0, 4'b0000, 32'h0,        32'hFFFF_FF80));
    vecs.push_back(mk(0, 3'd4, 32'h8000_0003, 32'h0,        5'd7,  32'h80FF_7F01, 0, 4'b0000, 32'h0,        32'h0000_0080));
    vecs.push_back(mk(0, 3'd1, 32'h8000_0002, 32'h0,        5'd9,  32'h80FF_7F01, 0, 4'b0000, 32'h0,        32'hFFFF_80FF));
    vecs.push_back(mk(0, 3'd5, 32'h8000_0002, 32'h0,        5'd9,  32'h80FF_7F01, 0, 4'b0000, 32'h0,        32'h0000_80FF));
    vecs.push_back(mk(0, 3'd0, 32'h8000_0001, 32'h0,        5'd3,  32'h80FF_7F01, 0, 4'b0000, 32'h0,        32'h0000_007F));
    vecs.push_back(mk(0, 3'd4, 32'h8000_0000, 32'h0,        5'd31, 32'h80FF_7F01, 0, 4'b0000, 32'h0,        32'h0000_0001));
    vecs.push_back(mk(0, 3'd1, 32'h8000_0000, 32'h0,        5'd4,  32'h1234_8001, 0, 4'b0000, 32'h0,        32'hFFFF_8001));
    vecs.push_back(mk(0, 3'd2, 32'h8000_0020, 32'h0,        5'd0,  32'h1234_5678, 0, 4'b0000, 32'h0,        32'h1234_5678));
    vecs.push_back(mk(1, 3'd1, 32'h8000_0002, 32'h1234_ABCD, 5'd0, 32'h0,         0, 4'b1100, 32'hABCD_ABCD, 32'h0));
    vecs.push_back(mk(1, 3'd2, 32'h8000_0004, 32'hCAFE_F00D, 5'd0, 32'h0,         0, 4'b1111, 32'hCAFE_F00D, 32'h0));
    vecs.push_back(mk(1, 3'd0, 32'h8000_0002, 32'h0000_0055, 5'd0, 32'h0,         0, 4'b0100, 32'h5555_5555, 32'h0));
    vecs.push_back(mk(1, 3'd2, 32'h8000_0006, 32'h1111_1111, 5'd0, 32'h0,         1, 4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(0, 3'd1, 32'h8000_0001, 32'h0,        5'd2,  32'h0,         1, 4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(0, 3'd2, 32'h8000_0002, 32'h0,        5'd2,  32'h0,         1, 4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(0, 3'd3, 32'h8000_0000, 32'h0,        5'd2,  32'h0,         1, 4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(1, 3'd4, 32'h8000_0000, 32'h0,        5'd0,  32'h0,         1, 4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(0, 3'd6, 32'h8000_0008, 32'h0,        5'd2,  32'h0,         1, 4'b0000, 32'h0,        32'h0));

    step();
    step();
    check("reset ex_ready", 32'(ex_ready), 32'd1);
    check("reset req_valid", 32'(mem_req_valid), 32'd0);
    check("reset req_addr", mem_req_addr, 32'h0);
    check("reset wstrb/we", {27'h0, mem_req_we, mem_req_wstrb}, 32'h0);
    check("reset req_wdata", mem_req_wdata, 32'h0);
    check("reset pulses", {29'h0, wb_valid, st_done, err_valid}, 32'h0);
    check("reset wb_rd/wb_data", wb_data | 32'(wb_rd), 32'h0);
    check("reset err_addr", err_addr, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_op(i, vecs[i]);

    // Response while idle must not produce anything.
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h5A5A_5A5A;
    step();
    mem_resp_valid = 1'b0;
    check("idle resp ignored", {29'h0, wb_valid, st_done, err_valid}, 32'h0);
    check("idle resp ex_ready", 32'(ex_ready), 32'd1);

    // SB with ready delayed 4 cycles; request must hold stable for all 5 REQ cycles.
    offer(1'b1, 3'd0, 32'h8000_0001, 32'h0000_00AB, 5'd0);
    mem_req_ready = 1'b0;
    step();
    ex_valid = 1'b0;
    ex_wdata = 32'hFFFF_FFFF;
    ex_addr = 32'h0;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) begin
        mem_req_ready = 1'b1;
        mem_resp_valid = 1'b1;
      end
      check($sformatf("sb hold c%0d valid", c), 32'(mem_req_valid), 32'd1);
      check($sformatf("sb hold c%0d addr", c), mem_req_addr, 32'h8000_0000);
      check($sformatf("sb hold c%0d wstrb/we", c), {27'h0, mem_req_we, mem_req_wstrb}, 32'h12);
      check($sformatf("sb hold c%0d wdata", c), mem_req_wdata, 32'hABAB_ABAB);
      step();
    end
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    check("sb same-cycle resp not taken", 32'(st_done), 32'd0);
    check("sb wait no req", 32'(mem_req_valid), 32'd0);
    step();
    check("sb still waiting", 32'(st_done | ex_ready), 32'd0);
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    check("sb st_done", 32'(st_done), 32'd1);
    check("sb no wb", 32'(wb_valid), 32'd0);
    step();
    check("sb idle", 32'(ex_ready), 32'd1);

    // Reset during WAIT drops the op; later response ignored.
    offer(1'b0, 3'd2, 32'h8000_0040, 32'h0, 5'd6);
    mem_req_ready = 1'b1;
    step();
    ex_valid = 1'b0;
    step();
    check("rst seq in wait", 32'(mem_req_valid | ex_ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst seq ex_ready", 32'(ex_ready), 32'd1);
    check("rst seq req_valid", 32'(mem_req_valid), 32'd0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h0BAD_0BAD;
    step();
    mem_resp_valid = 1'b0;
    check("rst seq no wb", {29'h0, wb_valid, st_done, err_valid}, 32'h0);
    step();
    check("rst seq still quiet", {29'h0, wb_valid, st_done, err_valid}, 32'h0);

`ifdef LSU_TIMEOUT_EN
    begin
      int n;
      n = 0;
      offer(1'b0, 3'd2, 32'h8000_0080, 32'h0, 5'd8);
      mem_req_ready = 1'b0;
      step();
      ex_valid = 1'b0;
      while (!err_valid && n < 40) begin
        step();
        n++;
      end
      check("timeout cycle", 32'(n), 32'd8);
      check("timeout err_valid", 32'(err_valid), 32'd1);
      check("timeout err_addr", err_addr, 32'h8000_0080);
      check("timeout req dropped", 32'(mem_req_valid), 32'd0);
      step();
      mem_resp_valid = 1'b1;
      step();
      mem_resp_valid = 1'b0;
      check("timeout late resp ignored", {29'h0, wb_valid, st_done, err_valid}, 32'h0);
      check("timeout idle", 32'(ex_ready), 32'd1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
- Load/store unit for the NPC core. Takes one memory instruction from execute and issues a word-aligned request on the data-memory bus using a valid/ready handshake.
- Waits for the response, then aligns and extends load data.
- Delivers the load result as the memory-data writeback source (MemtoReg=01) to the register file. Also reports store completion and alignment errors.

Parameters:
- TIMEOUT_CYCLES, 255: response watchdog limit in cycles; only used with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  memory op offered by execute
- ex_ready  out  1  LSU can accept an op (high only in IDLE)
- ex_is_store  in  1  1=store, 0=load
- ex_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- ex_addr  in  32  effective byte address
- ex_wdata  in  32  store data (rs2)
- ex_rd  in  5  load destination register
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts request
- mem_req_addr  out  32  {ex_addr[31:2],2'b00}
- mem_req_we  out  1  write enable
- mem_req_wstrb  out  4  byte strobes
- mem_req_wdata  out  32  store data shifted to lane
- mem_resp_valid  in  1  response/ack valid
- mem_resp_rdata  in  32  read word
- wb_valid  out  1  one-cycle load writeback pulse
- wb_rd  out  5  writeback register
- wb_data  out  32  extended load data
- st_done  out  1  one-cycle store completion pulse
- err_valid  out  1  one-cycle misalign/illegal pulse
- err_addr  out  32  faulting address

Behaviour:
- Reset: state=IDLE; ex_ready=1; mem_req_valid=0; mem_req_we=0; mem_req_wstrb=0; mem_req_addr=0; mem_req_wdata=0; wb_valid=0; wb_rd=0; wb_data=0; st_done=0; err_valid=0; err_addr=0.
- States: IDLE, REQ, WAIT, RESP, ERR.
- IDLE: on ex_valid&ex_ready, latch addr/funct3/wdata/rd/is_store. If legal and aligned -> REQ; else -> ERR.
- Legal loads: funct3 0,1,2,4,5. Legal stores: 0,1,2. Anything else is an error.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0.
- ERR: err_valid=1 and err_addr=latched addr for one cycle, then -> IDLE. No bus request is issued.
- REQ: mem_req_valid=1; addr/we/wstrb/wdata are held stable until mem_req_ready is sampled high, then -> WAIT.
  - SB: wstrb=1<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: wstrb=3<<addr[1:0], wdata={2{wdata[15:0]}}.
  - SW: wstrb=4'hF.
  - Loads: we=0, wstrb=0.
- WAIT: mem_req_valid=0. On mem_resp_valid, capture rdata -> RESP. A response arriving in the same cycle as ready is not accepted; responses are only taken in WAIT.
- RESP (1 cycle):
  - Load: wb_valid=1, wb_rd=latched rd.
  - Byte lane = rdata>>(8*addr[1:0]). LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
  - Store: st_done=1.
  - Then -> IDLE.
- Minimum latency, accept to wb_valid: 3 cycles (REQ, WAIT with resp, RESP) when ready and resp arrive immediately.
- rd=0 loads perform the access and pulse wb_valid with wb_rd=0; the register file discards it.
- mem_resp_valid outside WAIT is ignored.
- Reset in any state forces IDLE next cycle and drops the outstanding op. No wb_valid, st_done or err_valid follows.
- One op outstanding at a time; no pipelining.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entering REQ and increments in REQ and WAIT.
  - When it reaches TIMEOUT_CYCLES without completion: drop mem_req_valid, -> ERR, err_valid=1, err_addr=latched addr.
  - A late mem_resp_valid is then ignored.
- Undefined: no counter; REQ/WAIT wait indefinitely.

Test Plan:
- LW addr=0x80000010, ready and resp immediate, rdata=0xDEADBEEF, rd=5 -> mem_req_addr=0x80000010, wstrb=0; wb_valid 3 cycles after accept, wb_rd=5, wb_data=0xDEADBEEF.
- LB addr=0x80000003, rdata=0x80FF7F01 -> wb_data=0xFFFFFF80. Same access as LBU -> 0x00000080. LH addr=...02 -> 0xFFFF80FF.
- SB addr=0x80000001, wdata=0x000000AB, ready delayed 4 cycles -> request fields stable for 5 cycles, wstrb=4'b0010, wdata=0xABABABAB; st_done after resp.
- SW addr=0x80000006 -> no mem_req_valid; err_valid one cycle, err_addr=0x80000006; ex_ready high again the following cycle.
- rst asserted during WAIT, then resp arrives -> no wb_valid; ex_ready=1 the cycle after rst.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=8, resp never arrives -> err_valid at cycle 8 after entering REQ; a later resp is ignored.
